queue_uart_tx: RTL

- Downstream drain stage for the USB OUT-data byte queue.
- Pops bytes from the queue whenever it is non-empty and the block is enabled, then serialises each byte LSB-first onto the board `uart` pin as asynchronous serial.
- Supports optional parity and 1 or 2 stop bits.
- Runs in the 48 MHz USB clock domain, alongside the USB control logic that fills the queue.

---
 rtl/queue_uart_tx.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/queue_uart_tx.sv
// queue_uart_tx: drain stage for the USB OUT-data byte queue. Pops one byte
// whenever the queue is non-empty and the block is enabled, then sends it
// LSB-first as asynchronous serial with optional parity and 1 or 2 stop bits.
// Every output comes straight from a flop; no input reaches an output
// combinationally.
module queue_uart_tx #(
    parameter int CLKS_PER_BIT = 417,  // clk48mhz cycles per serial bit, 2..65535
    parameter int PARITY       = 0,    // 0 = none, 1 = odd, 2 = even
    parameter int STOP_BITS    = 1     // 1 or 2
) (
    input  logic        clk48mhz,
    input  logic        rst,
    input  logic        enable,
    input  logic        q_empty,
    input  logic [7:0]  q_data,
    output logic        q_r_clk,
    output logic        uart,
    output logic        busy,
    output logic [15:0] bytes_sent
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_WAIT,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

    logic [1:0]  rst_sync;
    logic        rst_n_int;

    state_t      state, state_n;
    logic [15:0] baud_cnt, baud_n;
    logic [2:0]  bit_cnt, bit_n;
    logic [7:0]  shreg, shreg_n;
    logic        par_bit, par_n;
    logic        uart_n;
    logic        q_r_clk_n;
    logic [15:0] bytes_n;
    logic        bit_done;

    // Reset release synchroniser: low rst clears everything at once, release
    // reaches the datapath two clk48mhz edges after rst goes high.
    always_ff @(posedge clk48mhz or negedge rst) begin
        if (!rst) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync[1];

    // The baud counter restarts at every bit boundary, so bit widths never drift.
    assign bit_done = (baud_cnt == BAUD_LAST);

    // State, counters, shift register and all registered outputs.
    always_ff @(posedge clk48mhz or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            uart       <= 1'b1;
            q_r_clk    <= 1'b0;
            busy       <= 1'b0;
            bytes_sent <= '0;
        end else begin
            // NOTE: flops take non-blocking assignments so every register sees
            // the pre-edge values of the others, whatever the statement order.
            state      <= state_n;
            baud_cnt   <= baud_n;
            bit_cnt    <= bit_n;
            shreg      <= shreg_n;
            par_bit    <= par_n;
            uart       <= uart_n;
            q_r_clk    <= q_r_clk_n;
            busy       <= (state_n != ST_IDLE);
            bytes_sent <= bytes_n;
        end
    end

    // Next-state, next-counter and next-output decode for the frame sequencer.
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through
        // the case below can leave one unassigned and infer a latch.
        state_n   = state;
        baud_n    = baud_cnt;
        bit_n     = bit_cnt;
        shreg_n   = shreg;
        par_n     = par_bit;
        uart_n    = uart;
        q_r_clk_n = 1'b0;
        bytes_n   = bytes_sent;

        case (state)
            ST_IDLE: begin
                uart_n = 1'b1;
                if (enable && !q_empty) begin
                    q_r_clk_n = 1'b1;
                    state_n   = ST_POP;
                end
            end

            // The queue pops on the q_r_clk rising edge; give it a cycle to settle.
            ST_POP: begin
                state_n = ST_WAIT;
            end

            ST_WAIT: begin
                shreg_n = q_data;
                par_n   = (PARITY == 1) ? ~^q_data : ^q_data;
                uart_n  = 1'b0;
                baud_n  = '0;
                state_n = ST_START;
            end

            ST_START: begin
                if (bit_done) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    uart_n  = shreg[0];
                    state_n = ST_DATA;
                end else begin
                    baud_n = baud_cnt + 16'd1;
                end
            end

            ST_DATA: begin
                if (bit_done) begin
                    baud_n = '0;
                    if (bit_cnt == 3'd7) begin
                        bit_n = '0;
                        if (PARITY != 0) begin
                            uart_n  = par_bit;
                            state_n = ST_PARITY;
                        end else begin
                            uart_n  = 1'b1;
                            state_n = ST_STOP;
                        end
                    end else begin
                        bit_n   = bit_cnt + 3'd1;
                        shreg_n = {1'b0, shreg[7:1]};
                        uart_n  = shreg[1];
                    end
                end else begin
                    baud_n = baud_cnt + 16'd1;
                end
            end

            ST_PARITY: begin
                if (bit_done) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    uart_n  = 1'b1;
                    state_n = ST_STOP;
                end else begin
                    baud_n = baud_cnt + 16'd1;
                end
            end

            ST_STOP: begin
                uart_n = 1'b1;
                if (bit_done) begin
                    baud_n = '0;
                    if (bit_cnt == STOP_LAST) begin
                        bit_n   = '0;
                        bytes_n = bytes_sent + 16'd1;
                        state_n = ST_IDLE;
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_n = baud_cnt + 16'd1;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule
